// File: rtl/wptr_ctrl_prog_if.sv
// Write-side bus of the async FIFO write-pointer controller.
// master = the writer/test side, slave = the pointer controller.
interface wptr_ctrl_prog_if #(
    parameter int PTR_WIDTH = 4
);
    logic                 we;
    logic [PTR_WIDTH:0]   g_rptr;
    logic [PTR_WIDTH:0]   af_thresh;
    logic                 af_load;
    logic                 ovf_clr;
    logic                 mem_we;
    logic [PTR_WIDTH-1:0] waddr;
    logic [PTR_WIDTH:0]   b_wptr;
    logic [PTR_WIDTH:0]   g_wptr;
    logic [PTR_WIDTH:0]   wr_count;
    logic                 full;
    logic                 almost_full;
    logic                 h_full;
    logic                 overflow;

    modport master (
        output we, g_rptr, af_thresh, af_load, ovf_clr,
        input  mem_we, waddr, b_wptr, g_wptr, wr_count,
               full, almost_full, h_full, overflow
    );

    modport slave (
        input  we, g_rptr, af_thresh, af_load, ovf_clr,
        output mem_we, waddr, b_wptr, g_wptr, wr_count,
               full, almost_full, h_full, overflow
    );
endinterface

// File: rtl/wptr_ctrl_prog.sv
// Write-domain pointer/flag controller for the async FIFO.
// Synchronizes the Gray read pointer, keeps binary/Gray write pointers,
// an exact occupancy count, full / half-full / programmable almost-full
// flags and a sticky overflow flag. Everything runs on wclk.
module wptr_ctrl_prog #(
    parameter int PTR_WIDTH   = 4,
    parameter int DEPTH       = 1 << PTR_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int AF_RESET    = DEPTH - 2
) (
    input  logic            wclk,
    input  logic            w_rst,
    wptr_ctrl_prog_if.slave bus
);
    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] DEPTH_P    = PW'(DEPTH);
    localparam logic [PTR_WIDTH:0] HALF_P     = PW'(DEPTH / 2);
    localparam logic [PTR_WIDTH:0] AF_RESET_P = PW'(AF_RESET);
    localparam logic [PTR_WIDTH:0] ONE_P      = PW'(1);

    logic [PTR_WIDTH:0] sync_q [SYNC_STAGES];
    logic [PTR_WIDTH:0] g_rptr_s;
    logic [PTR_WIDTH:0] b_rptr_s;

    logic [PTR_WIDTH:0] b_wptr_q;
    logic [PTR_WIDTH:0] g_wptr_q;
    logic [PTR_WIDTH:0] count_q;
    logic [PTR_WIDTH:0] thr_q;
    logic               full_q;
    logic               af_q;
    logic               hf_q;
    logic               ovf_q;

    logic               wr_ok;
    logic [PTR_WIDTH:0] b_wptr_next;
    logic [PTR_WIDTH:0] g_wptr_next;
    logic [PTR_WIDTH:0] count_next;
    logic [PTR_WIDTH:0] thr_load;
    logic               full_next;

    // Shift the Gray read pointer through the synchronizer chain
    always_ff @(posedge wclk or posedge w_rst) begin
        if (w_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.g_rptr;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign g_rptr_s = sync_q[SYNC_STAGES-1];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        b_rptr_s = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) b_rptr_s[i] = ^(g_rptr_s >> i);
    end

    // Next pointer, count and full decode
    always_comb begin
        wr_ok       = bus.we & ~full_q;
        b_wptr_next = b_wptr_q + PW'(wr_ok);
        g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1);
        count_next  = b_wptr_next - b_rptr_s;
        full_next   = (g_wptr_next == {~g_rptr_s[PTR_WIDTH -: 2], g_rptr_s[PTR_WIDTH-2:0]});
    end

    // Clamp a new almost-full threshold into 1..DEPTH before it is stored
    always_comb begin
        thr_load = bus.af_thresh;
        if (bus.af_thresh == '0) begin
            thr_load = ONE_P;
        end else if (bus.af_thresh > DEPTH_P) begin
            thr_load = DEPTH_P;
        end
    end

    // Pointer, count and flag registers
    always_ff @(posedge wclk or posedge w_rst) begin
        if (w_rst) begin
            b_wptr_q <= '0;
            g_wptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            hf_q     <= 1'b0;
        end else begin
            b_wptr_q <= b_wptr_next;
            g_wptr_q <= g_wptr_next;
            count_q  <= count_next;
            full_q   <= full_next;
            af_q     <= (count_next >= thr_q);
            hf_q     <= (count_next >= HALF_P);
        end
    end

    // Almost-full threshold register; the new value takes effect next cycle
    always_ff @(posedge wclk or posedge w_rst) begin
        if (w_rst) begin
            thr_q <= AF_RESET_P;
        end else if (bus.af_load) begin
            thr_q <= thr_load;
        end
    end

    // Sticky overflow: a write attempt while full sets it and beats a clear
    always_ff @(posedge wclk or posedge w_rst) begin
        if (w_rst) begin
            ovf_q <= 1'b0;
        end else if (bus.we & full_q) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.mem_we      = wr_ok;
    assign bus.waddr       = b_wptr_q[PTR_WIDTH-1:0];
    assign bus.b_wptr      = b_wptr_q;
    assign bus.g_wptr      = g_wptr_q;
    assign bus.wr_count    = count_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.h_full      = hf_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: doc/wptr_ctrl_prog.md
Name: wptr_ctrl_prog

Overview:
Parametrised write-side pointer/flag controller for the async FIFO, successor to the basic write-pointer controller. Adds an internal N-stage read-pointer synchronizer, an exact occupancy count, a runtime-programmable almost-full threshold, a memory write-enable, and a sticky overflow flag with clear. It lives entirely in the write clock domain. It drives the dual-port RAM write address and exports the Gray write pointer to the read domain.

Parameters:
PTR_WIDTH, 4, address bits; pointers are PTR_WIDTH+1 bits (MSB = wrap bit); must be >= 2
DEPTH, 1<<PTR_WIDTH, FIFO depth; fixed equal to 2**PTR_WIDTH (other values unsupported)
SYNC_STAGES, 2, flops in the g_rptr synchronizer; must be >= 2
AF_RESET, DEPTH-2, reset value of the internal almost-full threshold register

Ports:
wclk  in  1  write clock; all logic on the rising edge
w_rst  in  1  asynchronous, active-high reset
we  in  1  write request
g_rptr  in  PTR_WIDTH+1  Gray read pointer from the read domain (unsynchronized)
af_thresh  in  PTR_WIDTH+1  new almost-full threshold, 1..DEPTH
af_load  in  1  load af_thresh into the threshold register
ovf_clr  in  1  clear the sticky overflow flag
mem_we  out  1  RAM write enable = we & ~full (combinational)
waddr  out  PTR_WIDTH  RAM write address = b_wptr[PTR_WIDTH-1:0]
b_wptr  out  PTR_WIDTH+1  binary write pointer (registered)
g_wptr  out  PTR_WIDTH+1  Gray write pointer (registered; sole signal crossing to the read domain)
wr_count  out  PTR_WIDTH+1  occupancy seen by the writer, 0..DEPTH (registered)
full  out  1  registered full flag
almost_full  out  1  registered; wr_count >= threshold
h_full  out  1  registered; wr_count >= DEPTH/2
overflow  out  1  sticky; set by a write attempt while full

Behaviour:
- Reset (async assert, sync release): b_wptr=0, g_wptr=0, all sync flops=0, wr_count=0, full=0, almost_full=0, h_full=0, overflow=0, threshold=AF_RESET.
- Synchronizer: g_rptr passes through a SYNC_STAGES-flop chain giving g_rptr_s. g_rptr_s is Gray-to-binary converted to b_rptr_s (combinational, XOR-prefix from the MSB).
- Pointer update: b_wptr_next = b_wptr + (we & ~full), modulo 2**(PTR_WIDTH+1). g_wptr_next = b_wptr_next ^ (b_wptr_next>>1). Both are registered each cycle.
- full_next = (g_wptr_next == {~g_rptr_s[PTR_WIDTH:PTR_WIDTH-1], g_rptr_s[PTR_WIDTH-2:0]}). A write in the cycle that fills the FIFO raises full on the next edge, with no extra latency.
- Count: count_next = (b_wptr_next - b_rptr_s) mod 2**(PTR_WIDTH+1). This is exact across wrap; no wrap-case branch. wr_count <= count_next.
- almost_full <= (count_next >= thr_eff). h_full <= (count_next >= DEPTH/2). full and count_next==DEPTH are consistent by construction.
- Threshold: on af_load, thr <= af_thresh. thr_eff is used from the following cycle. Values of 0 are clamped to 1 and values > DEPTH are clamped to DEPTH at load time.
- Overflow: if we & full then overflow <= 1. Otherwise, if ovf_clr then overflow <= 0. Set wins over a simultaneous clear. A rejected write never moves pointers.
- Read pointer lag: b_rptr_s trails the true read pointer by SYNC_STAGES+ cycles. As a result, full, almost_full and wr_count are pessimistic (over-report) and never under-report. full deasserts SYNC_STAGES+1 wclk edges after g_rptr advances.
- Reset mid-operation: asserting w_rst returns all state to reset values immediately, regardless of pending writes. The read side must be reset together.

Test Plan:
- Reset: w_rst=1 with we=1 and toggling g_rptr -> all outputs 0, b_wptr=0, threshold=AF_RESET (14 for defaults), no mem_we pulse after release until we asserted with full=0.
- Fill (PTR_WIDTH=4, g_rptr held 0): 16 consecutive we cycles -> wr_count steps 1..16, h_full rises when wr_count=8, almost_full rises when wr_count=14, full=1 after 16th write, b_wptr=5'b10000, g_wptr=5'b11000.
- Overflow: full=1, pulse we for 3 cycles -> b_wptr unchanged, mem_we=0, overflow=1 sticky. Then ovf_clr and we together while still full -> overflow stays 1. Then ovf_clr alone -> overflow=0.
- Drain/lag: full FIFO, step g_rptr to Gray(4) -> full clears and wr_count=12 exactly SYNC_STAGES+1 edges later, not earlier.
- Wrap: run pointers through 3 full laps with interleaved reads at 1:1 rate -> wr_count never exceeds 16, matches scoreboard occupancy plus the sync lag, with correct count across the 31->0 pointer wrap.
- Threshold: af_load with af_thresh=5 at wr_count=6 -> almost_full=1 next cycle. af_thresh=0 -> acts as 1. af_thresh=20 -> acts as 16 (almost_full tracks full).
